// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int UART_DIV_W   = 16;
    localparam int UART_MIN_DIV = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_FETCH,
        TX_LOAD,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP,
        TX_NEXT
    } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable bit-period down-counter; tick marks the last cycle of each bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV_W = UART_DIV_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= period - DIV_W'(1);
        end else if (en) begin
            // terminal count reloads so back-to-back bits stay exactly period wide
            if (cnt == '0) begin
                cnt <= period - DIV_W'(1);
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pulls bytes from the TX FIFO and frames them as 8N1.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
//
// state  | meaning
// IDLE   | line high, waiting for tx_start_i
// FETCH  | read strobe to FIFO, or underrun if empty
// LOAD   | capture FIFO read data into shift register
// START  | start bit (low) for one bit time
// DATA   | DATA_W data bits, LSB first
// PARITY | even parity bit (UART_TX_PARITY_EN only)
// STOP   | STOP_BITS stop bits (high)
// NEXT   | bump sent count, finish burst or fetch again
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W    = UART_DATA_W,
    parameter int DIV_W     = UART_DIV_W,
    parameter int STOP_BITS = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              tx_start_i,
    input  logic [2:0]        tx_len_i,
    input  logic [DIV_W-1:0]  baud_div_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_en_o,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              underrun_o
);

    localparam int BIT_CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    tx_state_e         state;
    logic [2:0]        len_q;
    logic [2:0]        sent_q;
    logic [DIV_W-1:0]  div_q;
    logic [DATA_W-1:0] shift_q;
    logic [BIT_CW-1:0] bit_cnt;
    logic [1:0]        stop_cnt;
    logic              bit_tick;
    logic              timer_load;
    logic              timer_en;
`ifdef UART_TX_PARITY_EN
    logic              parity_q;
`endif

    assign fifo_rd_en_o = (state == TX_FETCH) && !fifo_empty_i;
    assign timer_load   = (state == TX_LOAD);
    assign timer_en     = (state == TX_START) || (state == TX_DATA) ||
                          (state == TX_PARITY) || (state == TX_STOP);

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load   (timer_load),
        .en     (timer_en),
        .period (div_q),
        .tick   (bit_tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= TX_IDLE;
            len_q      <= '0;
            sent_q     <= '0;
            div_q      <= '0;
            shift_q    <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= '0;
            tx_o       <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            underrun_o <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            done_o     <= 1'b0;
            underrun_o <= 1'b0;
            case (state)
                TX_IDLE: begin
                    tx_o <= 1'b1;
                    if (tx_start_i && (tx_len_i != 3'd0)) begin
                        len_q  <= tx_len_i;
                        // a divisor below the minimum would collapse the bit timer
                        div_q  <= (baud_div_i < DIV_W'(UART_MIN_DIV)) ?
                                  DIV_W'(UART_MIN_DIV) : baud_div_i;
                        sent_q <= '0;
                        busy_o <= 1'b1;
                        state  <= TX_FETCH;
                    end
                end
                TX_FETCH: begin
                    if (!fifo_empty_i) begin
                        state <= TX_LOAD;
                    end else begin
                        underrun_o <= 1'b1;
                        busy_o     <= 1'b0;
                        state      <= TX_IDLE;
                    end
                end
                TX_LOAD: begin
                    shift_q <= fifo_data_i;
`ifdef UART_TX_PARITY_EN
                    parity_q <= ^fifo_data_i;
`endif
                    bit_cnt <= '0;
                    tx_o    <= 1'b0;
                    state   <= TX_START;
                end
                TX_START: begin
                    if (bit_tick) begin
                        tx_o  <= shift_q[0];
                        state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (bit_tick) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt == BIT_CW'(DATA_W - 1)) begin
                            stop_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_o  <= parity_q;
                            state <= TX_PARITY;
`else
                            tx_o  <= 1'b1;
                            state <= TX_STOP;
`endif
                        end else begin
                            tx_o    <= shift_q[1];
                            bit_cnt <= bit_cnt + BIT_CW'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    if (bit_tick) begin
                        tx_o  <= 1'b1;
                        state <= TX_STOP;
                    end
                end
`endif
                TX_STOP: begin
                    if (bit_tick) begin
                        if (stop_cnt == 2'(STOP_BITS - 1)) begin
                            // done_o lands in NEXT, the cycle right after the last stop bit
                            done_o <= (sent_q + 3'd1 == len_q);
                            state  <= TX_NEXT;
                        end else begin
                            stop_cnt <= stop_cnt + 2'd1;
                        end
                    end
                end
                TX_NEXT: begin
                    sent_q <= sent_q + 3'd1;
                    if (sent_q + 3'd1 == len_q) begin
                        busy_o <= 1'b0;
                        state  <= TX_IDLE;
                    end else begin
                        state <= TX_FETCH;
                    end
                end
                default: begin
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= TX_IDLE;
                end
            endcase
        end
    end

    a_no_read_when_empty: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(fifo_rd_en_o && fifo_empty_i));

    a_busy_tracks_state: assert property (
        @(posedge clk_i) disable iff (!rst_ni) busy_o == (state != TX_IDLE));

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed and random bursts against a cycle-level frame model.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int STOP  = 1;
    localparam int FRAME = 1 + 8 + STOP + PAR;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        tx_start;
    logic [2:0]  tx_len;
    logic [15:0] baud_div;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_data;
    logic        tx_o;
    logic        busy;
    logic        done;
    logic        underrun;

    uart_tx_ctrl #(
        .DATA_W    (8),
        .DIV_W     (16),
        .STOP_BITS (STOP)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .tx_start_i   (tx_start),
        .tx_len_i     (tx_len),
        .baud_div_i   (baud_div),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (fifo_rd_en),
        .fifo_data_i  (fifo_data),
        .tx_o         (tx_o),
        .busy_o       (busy),
        .done_o       (done),
        .underrun_o   (underrun)
    );

    always #5 clk_i = ~clk_i;

    int         n_chk = 0;
    int         n_bad = 0;
    logic [4:0] obs;
    logic [7:0] fifo_q [$];
    bit         pend;
    int         sc_len, sc_d, sc_m;
    logic [7:0] sc_bytes [0:7];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Observed vector: {tx, busy, done, underrun, rd_en}; FIFO read data appears the cycle after a strobe.
    task automatic tick();
        @(negedge clk_i);
        obs = {tx_o, busy, done, underrun, fifo_rd_en};
        if (pend) begin
            if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
            pend = 1'b0;
        end
        if (obs[0]) pend = 1'b1;
        fifo_empty = (fifo_q.size() == 0);
    endtask

    // Cycle 0 is the cycle tx_start is high; frames follow at fixed arithmetic offsets.
    function automatic int burst_end();
        int fl;
        fl = FRAME * sc_d;
        if (sc_len == 0) return 0;
        if (sc_m >= sc_len) return 1 + (sc_len - 1) * (fl + 3) + 2 + fl;
        return 1 + sc_m * (fl + 3);
    endfunction

    function automatic logic [4:0] exp_at(input int c);
        int   fl, nf, be, f, s, b;
        logic tx, bz, dn, un, rd;
        tx = 1'b1; bz = 1'b0; dn = 1'b0; un = 1'b0; rd = 1'b0;
        if (sc_len != 0) begin
            fl = FRAME * sc_d;
            nf = (sc_m < sc_len) ? sc_m : sc_len;
            for (int k = 0; k < nf; k++) begin
                f = 1 + k * (fl + 3);
                s = f + 2;
                if (c == f) rd = 1'b1;
                if (c >= s && c < s + fl) begin
                    b = (c - s) / sc_d;
                    if (b == 0) tx = 1'b0;
                    else if (b <= 8) tx = sc_bytes[k][3'(b - 1)];
                    else if (PAR == 1 && b == 9) tx = ^sc_bytes[k];
                end
            end
            be = burst_end();
            if (sc_m >= sc_len) dn = (c == be);
            else un = (c == be + 1);
            bz = (c >= 1 && c <= be);
        end
        return {tx, bz, dn, un, rd};
    endfunction

    task automatic run_scn(input int id, input int len, input int d, input int m, input int abort);
        int         n;
        logic [4:0] e;
        sc_len = len;
        sc_d   = (d < 2) ? 2 : d;
        sc_m   = m;
        fifo_q.delete();
        pend = 1'b0;
        for (int i = 0; i < m; i++) fifo_q.push_back(sc_bytes[i]);
        fifo_empty = (fifo_q.size() == 0);
        tx_start = 1'b1;
        tx_len   = 3'(len);
        baud_div = 16'(d);
        n = burst_end() + 5;
        for (int c = 1; c <= n; c++) begin
            tick();
            e = exp_at(c);
            check($sformatf("s%0d c%0d", id, c), 32'(obs), 32'(e));
            if (c == abort) begin
                rst_ni = 1'b0;
                #1;
                check($sformatf("s%0d async_rst", id),
                      32'({tx_o, busy, done, underrun, fifo_rd_en}), 32'(5'b10000));
                fifo_q.delete();
                pend = 1'b0;
                fifo_empty = 1'b1;
                tx_start = 1'b0;
                @(negedge clk_i);
                check($sformatf("s%0d rst_hold", id), 32'({tx_o, busy}), 32'(2'b10));
                rst_ni = 1'b1;
                return;
            end
            tx_start = e[3] && ($urandom_range(0, 5) == 0);
            baud_div = 16'($urandom);
            tx_len   = 3'($urandom);
        end
        tx_start = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni     = 1'b0;
        tx_start   = 1'b0;
        tx_len     = 3'd0;
        baud_div   = 16'd0;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        pend       = 1'b0;
        repeat (3) @(negedge clk_i);
        obs = {tx_o, busy, done, underrun, fifo_rd_en};
        check("reset", 32'(obs), 32'(5'b10000));
        rst_ni = 1'b1;

        sc_bytes[0] = 8'hA5;
        run_scn(1, 1, 4, 1, 0);

        sc_bytes[0] = 8'h01; sc_bytes[1] = 8'h02; sc_bytes[2] = 8'h03;
        run_scn(2, 3, 2, 3, 0);

        sc_bytes[0] = 8'h3C;
        run_scn(3, 2, 3, 1, 0);

        sc_bytes[0] = 8'hC3;
        run_scn(4, 1, 0, 1, 0);

        sc_bytes[0] = 8'h11; sc_bytes[1] = 8'h22;
        run_scn(5, 0, 3, 2, 0);

        sc_bytes[0] = 8'h5A;
        run_scn(6, 1, 4, 1, 20);
        sc_bytes[0] = 8'h96;
        run_scn(7, 1, 4, 1, 0);

        sc_bytes[0] = 8'h07;
        run_scn(8, 1, 2, 1, 0);

        run_scn(9, 1, 2, 0, 0);

        sc_bytes[0] = 8'hFF;
        run_scn(10, 1, 1, 1, 0);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 8; i++) sc_bytes[i] = 8'($urandom);
            run_scn(100 + t, $urandom_range(0, 7), $urandom_range(0, 5), $urandom_range(0, 8), 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit sequencer for the UART peripheral. Pulls bytes one at a time from the 8-entry UART TX FIFO, which has a registered read port. Serialises each byte onto the TX line as an 8N1 frame at a programmable bit period. Sits between the register/config block, which issues the start command, and the TX FIFO plus pad.

Parameters:
DATA_W, 8, bits per character and width of the FIFO data path
DIV_W, 16, width of the baud divisor (clock cycles per bit)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  reset; asynchronous, active-low
tx_start_i  input  1  one-cycle pulse: start transmitting tx_len_i bytes
tx_len_i  input  3  number of bytes to send, 1..7; sampled on tx_start_i
baud_div_i  input  DIV_W  clock cycles per bit; sampled on tx_start_i
fifo_empty_i  input  1  TX FIFO empty flag
fifo_rd_en_o  output  1  TX FIFO read strobe, one cycle per byte
fifo_data_i  input  DATA_W  FIFO read data; valid the cycle after fifo_rd_en_o
tx_o  output  1  serial line; idles high
busy_o  output  1  high whenever state is not IDLE
done_o  output  1  one-cycle pulse after the last stop bit of a burst
underrun_o  output  1  one-cycle pulse when the FIFO is empty at a fetch

Behaviour:
- Reset values: tx_o=1, busy_o=0, done_o=0, underrun_o=0, fifo_rd_en_o=0, all counters 0, state IDLE.
- Reset takes effect asynchronously, including mid-frame: tx_o returns high immediately and the partial frame is abandoned.
- FSM states: IDLE, FETCH, LOAD, START, DATA, STOP, NEXT.
- IDLE:
  - tx_start_i=1 and tx_len_i!=0: latch len and div, clear the sent count, go to FETCH.
  - tx_len_i=0: command ignored, no done_o.
  - tx_start_i while not IDLE: ignored.
- FETCH:
  - fifo_empty_i=0: assert fifo_rd_en_o for exactly this cycle, go to LOAD.
  - fifo_empty_i=1: no read; pulse underrun_o, go to IDLE with no done_o; tx_o stays high.
- LOAD: latch fifo_data_i into the shift register, go to START.
- Bit timing: each bit is held for div cycles, counted by a bit-timer running div-1 down to 0. A latched div below 2 is forced to 2.
- START: tx_o=0 for one bit time.
- DATA: DATA_W bits, LSB first, shifting on each bit-timer expiry; a bit counter counts 0..DATA_W-1.
- STOP: tx_o=1 for STOP_BITS bit times.
- NEXT: increment the sent count.
  - sent==len: pulse done_o, go to IDLE.
  - otherwise: go to FETCH.
  - Inter-frame gap is 3 cycles of idle-high (NEXT, FETCH, LOAD).
- Latency: tx_start_i at cycle T → fifo_rd_en_o at T+1 → start bit begins at T+3.
- Frame length: (1+DATA_W+STOP_BITS)*div cycles.
- The controller never asserts fifo_rd_en_o while fifo_empty_i=1.
- Config changes during a burst have no effect until the next tx_start_i.

Optional Feature:
UART_TX_PARITY_EN
- Defined: state PARITY is inserted between DATA and STOP and drives the even-parity bit (XOR of the data bits) for one bit time. Frame becomes 8E1, (2+DATA_W+STOP_BITS)*div cycles.
- Undefined: no PARITY state; the frame is 8N1 as above.

Decomposition:
- Package uart_pkg:
  - tx_state_e enum covering all states, including PARITY.
  - Constants: UART_DATA_W=8, UART_DIV_W=16, UART_MIN_DIV=2.
- One natural sub-module, uart_baud_tick: loadable down-counter that emits a tick on expiry of div cycles. The FSM, shift register and byte counter stay in uart_tx_ctrl.

Test Plan:
- Single byte: FIFO holds 0xA5, div=4, len=1 → tx_o sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; one fifo_rd_en_o; done_o pulses 1 cycle after the stop bit ends.
- Burst: FIFO holds 0x01,0x02,0x03, len=3, div=2 → three frames, LSB first; exactly 3 read strobes; 3-cycle idle-high gaps between frames; one done_o.
- Underrun: FIFO holds 1 byte, len=2 → first frame sent; at the second fetch underrun_o pulses; no second fifo_rd_en_o; no done_o; busy_o=0.
- Divisor clamp and len=0: div=0, len=1 → bits are 2 cycles wide. len=0 → busy_o stays 0, no outputs change.
- Reset mid-frame: assert rst_ni=0 during DATA bit 3 → tx_o=1 immediately, busy_o=0. A new start after release sends a clean frame.
- Parity (with UART_TX_PARITY_EN): byte 0x07, div=2 → parity bit 1 after bit 7, then stop bit.
